// File: rtl/rx_receiver.sv
// Serial packet receiver: start bit, PKT_W data bits MSB first, stop bit.
// Checks the trailing CRC-8 (poly 0x07) and keeps a saturating error count.
module rx_receiver #(
  parameter int CLKS_PER_BIT = 50,
  parameter int PKT_W        = 136
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_line,
  output logic [PKT_W-1:0] rx_packet,
  output logic             rx_valid,
  output logic             crc_ok,
  output logic             frame_err,
  output logic             busy,
  output logic [7:0]       err_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(PKT_W);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PKT_W - 1);
  localparam logic [BIT_W-1:0] CRC_BITS = BIT_W'(PKT_W - 8);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t             state;
  logic               rx_m, rx_s;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [PKT_W-1:0]   shift;
  logic [7:0]         crc;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign busy = (state != IDLE);

  // NOTE: all state is registered with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the wide shift register is reset too; it is plain flops, not a RAM.
      state     <= IDLE;
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      crc       <= '0;
      rx_packet <= '0;
      crc_ok    <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      rx_m      <= rx_line;
      rx_s      <= rx_m;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF_BIT) begin
            cnt     <= '0;
            bit_cnt <= '0;
            crc     <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_BIT) begin
            cnt   <= '0;
            shift <= {shift[PKT_W-2:0], rx_s};
            if (bit_cnt < CRC_BITS) crc <= crc_step(crc, rx_s);
            if (bit_cnt == LAST_BIT) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_BIT) begin
            cnt <= '0;
            if (rx_s) begin
              rx_packet <= shift;
              crc_ok    <= (crc == shift[7:0]);
              state     <= DONE;
            end else begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
              state     <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // The stop bit still has half a bit left, so IDLE catches the next start.
          rx_valid <= 1'b1;
          if (!crc_ok) err_count <= sat_inc(err_count);
          cnt      <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_receiver.sv
// Scoreboard bench: inst 0 uses the 136-bit packet, inst 1 a 16-bit packet
// so the err_count saturation run stays short.
module tb_rx_receiver;

  localparam int CPB = 4;
  localparam int PW0 = 136;
  localparam int PW1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1, rx_line2 = 1'b1;
  logic [PW0-1:0] rx_packet;
  logic [PW1-1:0] rx_packet2;
  logic rx_valid, crc_ok, frame_err, busy;
  logic rx_valid2, crc_ok2, frame_err2, busy2;
  logic [7:0] err_count, err_count2;

  always #5 clk = ~clk;

  rx_receiver #(.CLKS_PER_BIT(CPB), .PKT_W(PW0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_line(rx_line), .rx_packet(rx_packet),
    .rx_valid(rx_valid), .crc_ok(crc_ok), .frame_err(frame_err),
    .busy(busy), .err_count(err_count));

  rx_receiver #(.CLKS_PER_BIT(CPB), .PKT_W(PW1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_line(rx_line2), .rx_packet(rx_packet2),
    .rx_valid(rx_valid2), .crc_ok(crc_ok2), .frame_err(frame_err2),
    .busy(busy2), .err_count(err_count2));

  typedef struct {
    logic [PW0-1:0] pkt;
    logic           ok;
    logic           ferr;
    logic [7:0]     err;
  } exp_t;

  exp_t q0[$], q1[$];
  int n_tests = 0, n_fail = 0;
  logic [PW0-1:0] last_pkt [2];
  logic           last_ok  [2];
  int             exp_err  [2];
  logic prev_ev0 = 1'b0, prev_ev1 = 1'b0;

  task automatic check(input string tag, input logic [PW0-1:0] got, input logic [PW0-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc_calc(input logic [PW0-1:0] p, input int n);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int i = n - 1; i >= 8; i--) begin
      fb = c[7] ^ p[i];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rx_line = v;
    else rx_line2 = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      last_pkt[i] = '0;
      last_ok[i]  = 1'b0;
      exp_err[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_line(0, 1'b1);
    set_line(1, 1'b1);
    wait_cyc(1);
    check("rst_packet", rx_packet, '0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_err1", err_count2, 0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input int inst, input logic [PW0-1:0] pkt, input int n, input logic stop);
    exp_t e;
    if (stop) begin
      last_pkt[inst] = pkt;
      last_ok[inst]  = (crc_calc(pkt, n) == pkt[7:0]);
      if (!last_ok[inst] && exp_err[inst] < 255) exp_err[inst]++;
    end else if (exp_err[inst] < 255) begin
      exp_err[inst]++;
    end
    e.pkt  = last_pkt[inst];
    e.ok   = last_ok[inst];
    e.ferr = !stop;
    e.err  = 8'(exp_err[inst]);
    if (inst == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // abort_bit >= 0 pulses reset while that data bit is on the line.
  task automatic send_frame(input int inst, input logic [PW0-1:0] pkt, input int n,
                            input logic stop, input int abort_bit);
    set_line(inst, 1'b0);
    wait_cyc(CPB);
    for (int i = n - 1; i >= 0; i--) begin
      set_line(inst, pkt[i]);
      if (n - 1 - i == abort_bit) begin
        wait_cyc(CPB / 2);
        do_reset();
        return;
      end
      wait_cyc(CPB);
    end
    push_exp(inst, pkt, n, stop);
    set_line(inst, stop);
    wait_cyc(CPB);
    set_line(inst, 1'b1);
  endtask

  function automatic logic [PW0-1:0] good_pkt(input logic [PW0-1:0] payload);
    logic [PW0-1:0] p = payload;
    p[7:0] = crc_calc(p, PW0);
    return p;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (rx_valid || frame_err)) begin
      check("pulse_width0", prev_ev0, 0);
      if (q0.size() == 0) check("unexpected0", 1, 0);
      else begin
        e = q0.pop_front();
        check("ferr0", frame_err, e.ferr);
        check("valid0", rx_valid, !e.ferr);
        check("packet0", rx_packet, e.pkt);
        check("crc_ok0", crc_ok, e.ok);
        check("err0", err_count, e.err);
      end
    end
    if (rst_n && (rx_valid2 || frame_err2)) begin
      check("pulse_width1", prev_ev1, 0);
      if (q1.size() == 0) check("unexpected1", 1, 0);
      else begin
        e = q1.pop_front();
        check("ferr1", frame_err2, e.ferr);
        check("packet1", rx_packet2, e.pkt);
        check("crc_ok1", crc_ok2, e.ok);
        check("err1", err_count2, e.err);
      end
    end
    prev_ev0 = rx_valid | frame_err;
    prev_ev1 = rx_valid2 | frame_err2;
  end

  initial begin
    logic [PW0-1:0] p;
    int busy_cycles;
    model_reset();
    wait_cyc(2);
    do_reset();
    wait_cyc(4);

    // Zero frame, then zero payload with a wrong CRC byte.
    send_frame(0, '0, PW0, 1'b1, -1);
    p = '0;
    p[7:0] = 8'h01;
    send_frame(0, p, PW0, 1'b1, -1);

    // Back-to-back good frames with distinct patterns.
    p = '0;
    for (int i = 0; i < PW0; i += 2) p[i] = 1'b1;
    send_frame(0, good_pkt(p), PW0, 1'b1, -1);
    send_frame(0, good_pkt('1), PW0, 1'b1, -1);
    p = {$urandom, $urandom, $urandom, $urandom, $urandom};
    send_frame(0, good_pkt(p), PW0, 1'b1, -1);
    wait_cyc(3 * CPB);

    // Framing error on an otherwise valid frame.
    p = {$urandom, $urandom, $urandom, $urandom, $urandom};
    send_frame(0, good_pkt(p), PW0, 1'b0, -1);
    wait_cyc(4 * CPB);

    // One-cycle glitch.
    set_line(0, 1'b0);
    wait_cyc(1);
    set_line(0, 1'b1);
    busy_cycles = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy) busy_cycles++;
      wait_cyc(1);
    end
    check("glitch_busy_cycles", busy_cycles, CPB / 2);
    check("glitch_idle", busy, 0);
    check("glitch_packet", rx_packet, last_pkt[0]);
    check("glitch_err", err_count, exp_err[0]);

    // Reset during data bit 60, then a good frame.
    p = {$urandom, $urandom, $urandom, $urandom, $urandom};
    send_frame(0, good_pkt(p), PW0, 1'b1, 60);
    wait_cyc(3 * CPB);
    send_frame(0, good_pkt(p), PW0, 1'b1, -1);
    wait_cyc(3 * CPB);

    // Saturation: back-to-back bad-CRC frames on the short instance.
    for (int f = 0; f < 260; f++) begin
      p = '0;
      p[15:8] = 8'($urandom);
      p[7:0] = crc_calc(p, PW1) ^ 8'h01;
      send_frame(1, p, PW1, 1'b1, -1);
    end
    wait_cyc(3 * CPB);
    check("sat_err", err_count2, 8'hFF);

    for (int k = 0; k < 2000 && (q0.size() != 0 || q1.size() != 0); k++) wait_cyc(1);
    check("drain", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
